// File: rtl/lsu_bus_ctrl_if.sv
// Request/response and data-memory bus bundle for lsu_bus_ctrl.
// master = the LSU sequencer, slave = the datapath plus memory environment.
interface lsu_bus_ctrl_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_dmtype;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic              stall;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    input  req_valid, req_we, req_dmtype, req_addr, req_wdata,
           bus_gnt, bus_rvalid, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, stall,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output req_valid, req_we, req_dmtype, req_addr, req_wdata,
           bus_gnt, bus_rvalid, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, stall,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store sequencer: one access per handshake onto a word-aligned grant/response bus.
// Optional macro LSU_MISALIGN_SPLIT_EN: misaligned accesses complete (split into two beats if crossing a word).
//
// state  | meaning
// IDLE   | req_ready high, waiting for an access
// REQ    | bus_req high, waiting for bus_gnt
// WAIT   | waiting for bus_rvalid of the first beat
// REQ2   | second beat request (split build only)
// WAIT2  | waiting for bus_rvalid of the second beat (split build only)
// RESP   | one-cycle rsp_valid, then back to IDLE
module lsu_bus_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  lsu_bus_ctrl_if.master lsu
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_RESP
`ifdef LSU_MISALIGN_SPLIT_EN
    , S_REQ2, S_WAIT2
`endif
  } state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  dt_q;
  logic [1:0]  off_q;

  logic [2:0]  dt;
  logic [1:0]  off;
  logic        is_word, is_half, is_byte, illegal, misalign;
  logic [3:0]  base_be;
  logic [31:0] wrep;
  logic [31:0] single_lane;

  assign dt      = lsu.req_dmtype;
  assign off     = lsu.req_addr[1:0];
  assign is_word = (dt == 3'b000);
  assign is_half = (dt == 3'b001) || (dt == 3'b010);
  assign is_byte = (dt == 3'b011) || (dt == 3'b100);
  assign illegal = !(is_word || is_half || is_byte) ||
                   (lsu.req_we && ((dt == 3'b010) || (dt == 3'b100)));
  assign misalign = (is_half && off[0]) || (is_word && (off != 2'b00));
  assign base_be = is_word ? 4'b1111 : (is_half ? 4'b0011 : 4'b0001);
  assign wrep    = is_word ? lsu.req_wdata :
                   (is_half ? {2{lsu.req_wdata[15:0]}} : {4{lsu.req_wdata[7:0]}});
  assign single_lane = lsu.bus_rdata >> {off_q, 3'b000};

  assign lsu.stall = (lsu.req_valid && lsu.req_ready) || !lsu.req_ready;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [7:0]  be8;
  logic [63:0] wd64;
  logic [63:0] merged;
  logic        split_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wd_hi_q;
  logic [31:0] lo_q;

  // enables/data spread over two words; the upper half belongs to the next word
  assign be8    = {4'b0000, base_be} << off;
  assign wd64   = {32'h0, lsu.req_wdata} << {off, 3'b000};
  assign merged = {lsu.bus_rdata, lo_q} >> {off_q, 3'b000};
`else
  logic [3:0]  be4;
  assign be4 = base_be << off;
`endif

  function automatic logic [31:0] load_ext(input logic [2:0] t, input logic [31:0] lane);
    case (t)
      3'b000:  load_ext = lane;
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {16'h0, lane[15:0]};
      3'b011:  load_ext = {{24{lane[7]}}, lane[7:0]};
      default: load_ext = {24'h0, lane[7:0]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      lsu.req_ready <= 1'b1;
      lsu.bus_req   <= 1'b0;
      lsu.bus_we    <= 1'b0;
      lsu.bus_addr  <= '0;
      lsu.bus_be    <= 4'b0000;
      lsu.bus_wdata <= 32'h0;
      lsu.rsp_valid <= 1'b0;
      lsu.rsp_rdata <= 32'h0;
      lsu.rsp_fault <= 1'b0;
      we_q          <= 1'b0;
      dt_q          <= 3'b000;
      off_q         <= 2'b00;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q       <= 1'b0;
      be_hi_q       <= 4'b0000;
      wd_hi_q       <= 32'h0;
      lo_q          <= 32'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu.req_valid && lsu.req_ready) begin
            we_q          <= lsu.req_we;
            dt_q          <= dt;
            off_q         <= off;
            lsu.req_ready <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (illegal) begin
`else
            if (illegal || misalign) begin
`endif
              state         <= S_RESP;
              lsu.rsp_valid <= 1'b1;
              lsu.rsp_fault <= 1'b1;
              lsu.rsp_rdata <= 32'h0;
            end else begin
              state         <= S_REQ;
              lsu.bus_req   <= 1'b1;
              lsu.bus_we    <= lsu.req_we;
              lsu.bus_addr  <= {lsu.req_addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_MISALIGN_SPLIT_EN
              lsu.bus_be    <= be8[3:0];
              lsu.bus_wdata <= misalign ? wd64[31:0] : wrep;
              split_q       <= (be8[7:4] != 4'b0000);
              be_hi_q       <= be8[7:4];
              wd_hi_q       <= wd64[63:32];
`else
              lsu.bus_be    <= be4;
              lsu.bus_wdata <= wrep;
`endif
            end
          end
        end
        S_REQ: begin
          if (lsu.bus_gnt) begin
            state       <= S_WAIT;
            lsu.bus_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (lsu.bus_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (split_q) begin
              lo_q          <= lsu.bus_rdata;
              state         <= S_REQ2;
              lsu.bus_req   <= 1'b1;
              lsu.bus_addr  <= lsu.bus_addr + ADDR_W'(4);
              lsu.bus_be    <= be_hi_q;
              lsu.bus_wdata <= wd_hi_q;
            end else
`endif
            begin
              state         <= S_RESP;
              lsu.rsp_valid <= 1'b1;
              lsu.rsp_fault <= 1'b0;
              lsu.rsp_rdata <= we_q ? 32'h0 : load_ext(dt_q, single_lane);
            end
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        S_REQ2: begin
          if (lsu.bus_gnt) begin
            state       <= S_WAIT2;
            lsu.bus_req <= 1'b0;
          end
        end
        S_WAIT2: begin
          if (lsu.bus_rvalid) begin
            state         <= S_RESP;
            lsu.rsp_valid <= 1'b1;
            lsu.rsp_fault <= 1'b0;
            lsu.rsp_rdata <= we_q ? 32'h0 : load_ext(dt_q, merged[31:0]);
          end
        end
`endif
        S_RESP: begin
          state         <= S_IDLE;
          lsu.rsp_valid <= 1'b0;
          lsu.rsp_fault <= 1'b0;
          lsu.rsp_rdata <= 32'h0;
          lsu.req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
